// File: rtl/ins_boot_loader.sv
// ins_boot_loader: boot-time imem loader that hands the imem port to the core fetch path once loading completes
// Optional feature: define INS_BOOT_LOADER_CKSUM_EN to verify a trailer word holding the 32-bit wrapping sum of all loaded words.
// Ports:
//   clk, nrst                      clock (rising edge), asynchronous active-low reset
//   reload                         single-cycle restart pulse (accepted in IDLE/DONE/ERR)
//   exIns_ren/addr/valid/in        external instruction source handshake
//   core_ren/addr/rdata/stall      core fetch path
//   imem_cs/we/addr/wdata/rdata    imem macro port (synchronous read, 1-cycle latency)
//   load_done, load_err            status levels
module ins_boot_loader #(
    parameter int          ADDR_W     = 8,
    parameter int          LOAD_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          TIMEOUT    = 64,
    parameter bit          AUTO_BOOT  = 1'b1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              reload,
    input  logic              exIns_valid,
    input  logic [31:0]       exIns_in,
    output logic              exIns_ren,
    output logic [31:0]       exIns_addr,
    input  logic              core_ren,
    input  logic [31:0]       core_addr,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              imem_cs,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              load_done,
    output logic              load_err
);
    typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, ERR} state_t;
    localparam int              TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(LOAD_WORDS - 1);
    localparam logic [31:0]     NOP   = 32'h0000_0013;
    state_t          r_state;
    logic            r_ren;
    logic [ADDR_W:0] r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic [31:0]     r_wdata;
    logic            w_done;
    logic            w_unused;
`ifdef INS_BOOT_LOADER_CKSUM_EN
    logic [31:0]     r_sum;
    logic            r_chk;
`endif
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= AUTO_BOOT ? REQ : IDLE;
            r_ren   <= 1'b0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_wdata <= '0;
`ifdef INS_BOOT_LOADER_CKSUM_EN
            r_sum   <= '0;
            r_chk   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE, ERR: if (reload) begin
                    r_state <= REQ;
                    r_ren   <= 1'b1;
                    r_cnt   <= '0;
                    r_tcnt  <= '0;
`ifdef INS_BOOT_LOADER_CKSUM_EN
                    r_sum   <= '0;
                    r_chk   <= 1'b0;
`endif
                end
                // Coming out of reset the request is raised one cycle late so exIns_ren resets low.
                REQ: if (!r_ren) begin
                    r_ren <= 1'b1;
                end else if (exIns_valid) begin
                    r_ren   <= 1'b0;
                    r_tcnt  <= '0;
                    r_wdata <= exIns_in;
                    r_state <= WRITE;
`ifdef INS_BOOT_LOADER_CKSUM_EN
                    // The trailer fetch is compared, never written.
                    if (r_chk) r_state <= (exIns_in == r_sum) ? DONE : ERR;
`endif
                end else if (r_tcnt == TLAST) begin
                    r_ren   <= 1'b0;
                    r_state <= ERR;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                WRITE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_tcnt  <= '0;
                    r_ren   <= 1'b1;
                    r_state <= REQ;
`ifdef INS_BOOT_LOADER_CKSUM_EN
                    r_sum   <= r_sum + r_wdata;
                    if (r_cnt == LAST) r_chk <= 1'b1;
`else
                    if (r_cnt == LAST) begin
                        r_ren   <= 1'b0;
                        r_state <= DONE;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign w_done     = r_state == DONE;
    assign exIns_ren  = r_ren;
    assign exIns_addr = BASE_ADDR + 32'({r_cnt, 2'b00});
    assign core_stall = !w_done;
    assign load_done  = w_done;
    assign load_err   = r_state == ERR;
    // In DONE the imem port is a straight pass-through, so the macro's own read latency is what the core sees.
    assign imem_cs    = w_done ? core_ren : r_state == WRITE;
    assign imem_we    = r_state == WRITE;
    assign imem_addr  = w_done ? core_addr[ADDR_W+1:2] : r_cnt[ADDR_W-1:0];
    assign imem_wdata = r_wdata;
    assign core_rdata = w_done ? imem_rdata : NOP;
    assign w_unused   = &{1'b0, core_addr[31:ADDR_W+2], core_addr[1:0]};
endmodule
